// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC sequencing, one-deep request tracking and a small
// {pc, instr} buffer toward decode. Optional trap on misaligned redirect: FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_misalign
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  fetch_entry_t     r_fifo [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pc;
  logic [31:0]      r_pend_pc;
  logic             r_pend;

  logic             w_halted;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [OCC_W-1:0] w_occ;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_halted;
  assign w_halted       = r_halted;
  assign fetch_misalign = r_halted;
`else
  assign w_halted       = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  // Credit check: buffered words plus the one in flight must leave room after this edge's pop.
  assign w_pop   = (r_count != '0) && out_ready;
  assign w_push  = r_pend && !redirect_valid;
  assign w_occ   = OCC_W'(r_count) + OCC_W'(r_pend) - OCC_W'(w_pop);
  assign w_issue = !redirect_valid && !w_halted && (w_occ < OCC_W'(DEPTH));

  assign instr_addr = r_pc;
  assign out_valid  = (r_count != '0);
  assign out_instr  = r_fifo[r_rd_ptr].instr;
  assign out_pc     = r_fifo[r_rd_ptr].pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= RESET_PC;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_halted  <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Redirect flushes the buffer and drops the in-flight word.
      r_pend   <= 1'b0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        r_halted <= 1'b1;
      end else begin
        r_halted <= 1'b0;
        r_pc     <= redirect_pc;
      end
`else
      r_pc <= redirect_pc & ~32'h0000_0003;
`endif
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_pend  <= w_issue;
      if (w_issue) begin
        r_pend_pc <= r_pc;
        r_pc      <= r_pc + 32'd4;
      end
    end
  end

  // Buffer storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo[r_wr_ptr] <= '{pc: r_pend_pc, instr: instr};
    end
  end

endmodule
